data_mem_responder: RTL and testbench

- Word-addressed data memory that acts as the responder end of the core's LSU data port.
- Accepts single-cycle write strobes and read requests from the core, and returns read data with a read-valid pulse after a programmable number of wait states.
- Sits beside the core at top level:
  - core data_addr_o / data_w_req_o / data_w_o / data_r_req_o drive this block's inputs;
  - this block's data_r_o / read_data_vaild_o drive core data_r_i / read_data_vaild_i.

---
 rtl/data_mem_responder.sv | 73 +++++++
 tb/tb_data_mem_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory answering the core LSU data port,
// returning read data with a one-cycle valid pulse after READ_LATENCY edges.
module data_mem_responder #(
    parameter int          DEPTH        = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_addr_i,
    input  logic        data_w_req_i,
    input  logic [31:0] data_w_i,
    input  logic        data_r_req_i,
    output logic [31:0] data_r_o,
    output logic        read_data_vaild_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] HI_MASK = ~32'(DEPTH * 4 - 1);
    localparam logic [3:0]  LAT_M1  = 4'(READ_LATENCY - 1);
    localparam logic [1:0]  IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic          inr_q;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   mem_q;
    logic          in_range, idle, wr, rd, to_resp, inr_next, err_set;
    // BASE_ADDR is aligned to the array size, so range check is a match on the upper bits
    assign in_range = ((data_addr_i ^ BASE_ADDR) & HI_MASK) == 32'd0;
    assign idle     = state == IDLE;
    assign wr       = idle && data_w_req_i && in_range;
    assign rd       = idle && data_r_req_i && !data_w_req_i;
    assign inr_next = rd ? in_range : inr_q;
    assign to_resp  = (rd && LAT_M1 == 4'd0) || (state == WAIT && cnt == 4'd1);
    assign err_set  = (!idle && (data_w_req_i || data_r_req_i))
                   || (idle && data_w_req_i && (data_r_req_i || !in_range))
                   || (to_resp && !inr_next);
    assign busy_o   = !idle;
    assign data_r_o = (read_data_vaild_o && inr_q) ? mem_q : 32'd0;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= 4'd0;
            idx_q             <= '0;
            inr_q             <= 1'b0;
            read_data_vaild_o <= 1'b0;
            err_o             <= 1'b0;
        end else begin
            read_data_vaild_o <= state == RESP;
            err_o             <= err_o | err_set;
            if (rd) begin
                idx_q <= data_addr_i[AW+1:2];
                inr_q <= in_range;
                cnt   <= LAT_M1;
                state <= (LAT_M1 == 4'd0) ? RESP : WAIT;
            end else if (state == WAIT) begin
                cnt   <= cnt - 4'd1;
                state <= (cnt == 4'd1) ? RESP : WAIT;
            end else if (state == RESP) begin
                state <= IDLE;
            end
        end
    end
    // Array has no reset so it maps onto block RAM; read port is registered
    always_ff @(posedge clock) begin
        if (wr)
            mem[data_addr_i[AW+1:2]] <= data_w_i;
        if (state == RESP)
            mem_q <= mem[idx_q];
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed stimulus with a queue scoreboard; a negedge
// monitor checks every valid pulse for data and cycle of arrival.
module tb_data_mem_responder;
    localparam int L = 2;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_addr_i = '0;
    logic        data_w_req_i = 1'b0;
    logic [31:0] data_w_i = '0;
    logic        data_r_req_i = 1'b0;
    logic [31:0] data_r_o;
    logic        read_data_vaild_o, busy_o, err_o;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;
    exp_t q[$];

    data_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .READ_LATENCY(L)) dut (
        .clock(clock), .reset(reset), .data_addr_i(data_addr_i),
        .data_w_req_i(data_w_req_i), .data_w_i(data_w_i), .data_r_req_i(data_r_req_i),
        .data_r_o(data_r_o), .read_data_vaild_o(read_data_vaild_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (read_data_vaild_o) begin
                if (q.size() == 0)
                    chk("unexpected_valid", {31'd0, read_data_vaild_o}, 32'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("read_data", data_r_o, e.d);
                    chk("read_latency", 32'(cyc), 32'(e.due));
                end
            end else
                chk("data_zero_when_idle", data_r_o, 32'd0);
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        data_addr_i = a; data_w_i = d; data_w_req_i = 1'b1;
        @(negedge clock);
        data_w_req_i = 1'b0;
    endtask

    task automatic issue_read(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        data_addr_i = a; data_r_req_i = 1'b1;
        q.push_back('{d, cyc + 1 + L});
        @(negedge clock);
        data_r_req_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL read_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d);
        issue_read(a, d);
        wait_done();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_data", data_r_o, 32'd0);
        chk("rst_valid", {31'd0, read_data_vaild_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        reset = 1'b0;

        do_write(32'h10, 32'hDEAD_BEEF);
        issue_read(32'h10, 32'hDEAD_BEEF);
        chk("busy_c1", {31'd0, busy_o}, 32'd1);
        @(negedge clock);
        chk("busy_c2", {31'd0, busy_o}, 32'd1);
        @(negedge clock);
        chk("busy_c3", {31'd0, busy_o}, 32'd0);
        wait_done();
        chk("err_after_read", {31'd0, err_o}, 32'd0);

        do_write(32'h0, 32'h1111_1111);
        do_write(32'h4, 32'h2222_2222);
        do_read(32'h4, 32'h2222_2222);
        do_read(32'h0, 32'h1111_1111);
        chk("err_back_to_back", {31'd0, err_o}, 32'd0);

        do_write(32'h8, 32'h3333_3333);
        issue_read(32'h8, 32'h3333_3333);
        data_addr_i = 32'h8; data_w_i = 32'h5555_5555; data_w_req_i = 1'b1;
        @(negedge clock);
        data_w_req_i = 1'b0;
        wait_done();
        do_read(32'h8, 32'h3333_3333);
        chk("err_write_in_wait", {31'd0, err_o}, 32'd1);

        do_reset();
        chk("err_cleared", {31'd0, err_o}, 32'd0);
        do_read(32'h1000, 32'd0);
        chk("err_oor_read", {31'd0, err_o}, 32'd1);
        do_reset();
        do_write(32'h1000, 32'hFFFF_FFFF);
        chk("err_oor_write", {31'd0, err_o}, 32'd1);
        do_read(32'h0, 32'h1111_1111);
        do_read(32'h4, 32'h2222_2222);

        do_reset();
        @(negedge clock);
        data_addr_i = 32'h20; data_w_i = 32'hA5A5_A5A5;
        data_w_req_i = 1'b1; data_r_req_i = 1'b1;
        @(negedge clock);
        data_w_req_i = 1'b0; data_r_req_i = 1'b0;
        chk("busy_after_collision", {31'd0, busy_o}, 32'd0);
        repeat (5) @(negedge clock);
        chk("err_collision", {31'd0, err_o}, 32'd1);
        do_read(32'h20, 32'hA5A5_A5A5);

        issue_read(32'h10, 32'hDEAD_BEEF);
        #2 reset = 1'b1;
        q.delete();
        #1;
        chk("midread_busy", {31'd0, busy_o}, 32'd0);
        chk("midread_err", {31'd0, err_o}, 32'd0);
        chk("midread_valid", {31'd0, read_data_vaild_o}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        do_read(32'h10, 32'hDEAD_BEEF);
        chk("err_final", {31'd0, err_o}, 32'd0);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
